// File: rtl/nn_interp_pkg.sv
// Shared defaults and FSM state type for the activation table fetcher.
package nn_interp_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_FRAC_W = 4;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BASE = 2'd1,
    WAIT_NEXT = 2'd2,
    HOLD      = 2'd3
  } state_t;

endpackage

// File: rtl/activation_table_fetcher.sv
// Fetches two neighbouring activation-table words plus the fraction for a downstream interpolator.
// Optional index cache enabled by defining ACT_TABLE_INDEX_CACHE_EN.
module activation_table_fetcher
  import nn_interp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x,
  output logic                     tbl_rd,
  output logic [ADDR_W-1:0]        tbl_addr,
  input  logic signed [DATA_W-1:0] tbl_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] base,
  output logic signed [DATA_W-1:0] next_data,
  output logic signed [DATA_W-1:0] remaining,
  output state_t                   fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // out_valid, once raised, stays high with stable operands until out_ready is seen.

  state_t                     state, next_state;
  logic signed [DATA_W-FRAC_W-1:0] int_part;
  logic [ADDR_W-1:0]          idx, idx_q, next_idx;
  logic [DATA_W-1:0]          frac_ext;
  logic                       accept;
  logic                       cache_hit;

  // Signed integer part is offset by half the table so -8..7 lands on 0..15.
  assign int_part = x[DATA_W-1:FRAC_W];
  assign idx      = ADDR_W'(int_part) + ADDR_W'(1 << (ADDR_W - 1));
  assign frac_ext = DATA_W'(x[FRAC_W-1:0]);
  assign next_idx = (idx_q == {ADDR_W{1'b1}}) ? idx_q : idx_q + 1'b1;
  assign accept   = (state == IDLE) && in_valid;
  assign fsm_state = state;

`ifdef ACT_TABLE_INDEX_CACHE_EN
  logic [ADDR_W-1:0] cache_idx;
  logic              cache_vld;

  assign cache_hit = cache_vld && (cache_idx == idx);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cache_idx <= '0;
      cache_vld <= 1'b0;
    end else if (state == WAIT_NEXT) begin
      cache_idx <= idx_q;
      cache_vld <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    tbl_rd     = 1'b0;
    tbl_addr   = '0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cache_hit) begin
            next_state = HOLD;
          end else begin
            tbl_rd     = 1'b1;
            tbl_addr   = idx;
            next_state = WAIT_BASE;
          end
        end
      end
      WAIT_BASE: begin
        tbl_rd     = 1'b1;
        tbl_addr   = next_idx;
        next_state = WAIT_NEXT;
      end
      WAIT_NEXT: next_state = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Reset holds every output quiet, including the cycle it is first asserted.
    if (!rst) begin
      next_state = IDLE;
      in_ready   = 1'b0;
      tbl_rd     = 1'b0;
      tbl_addr   = '0;
      out_valid  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      idx_q     <= '0;
      base      <= '0;
      next_data <= '0;
      remaining <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        idx_q     <= idx;
        remaining <= frac_ext;
      end
      if (state == WAIT_BASE) base <= tbl_data;
      if (state == WAIT_NEXT) next_data <= tbl_data;
    end
  end

endmodule

// File: tb/tb_activation_table_fetcher.sv
// Directed bench for activation_table_fetcher against a ROM holding tbl[k] = 3*k.
module tb_activation_table_fetcher;
  import nn_interp_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x;
  logic              tbl_rd;
  logic [3:0]        tbl_addr;
  logic signed [7:0] tbl_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] base;
  logic signed [7:0] next_data;
  logic signed [7:0] remaining;
  state_t            fsm_state;

  int tests = 0;
  int fails = 0;

  activation_table_fetcher dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .tbl_rd    (tbl_rd),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .base      (base),
    .next_data (next_data),
    .remaining (remaining),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  // Table ROM: word is available the cycle after the read strobe.
  always @(posedge clk) begin
    if (tbl_rd) tbl_data <= 8'(3 * int'(tbl_addr));
    else        tbl_data <= 8'h5A;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_fetch(input string tag, input logic [7:0] xv,
                           input int a0, input int a1,
                           input int b, input int n, input int r, input int hold);
    tick();
    in_valid = 1'b1;
    x = xv;
    @(negedge clk);
    chk({tag, " in_ready"}, 32'(in_ready), 1);
    chk({tag, " rd0"}, 32'(tbl_rd), 1);
    chk({tag, " addr0"}, 32'(tbl_addr), a0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, " rd1"}, 32'(tbl_rd), 1);
    chk({tag, " addr1"}, 32'(tbl_addr), a1);
    chk({tag, " busy"}, 32'(in_ready), 0);
    chk({tag, " early_valid"}, 32'(out_valid), 0);
    tick();
    @(negedge clk);
    chk({tag, " rd_idle"}, 32'(tbl_rd), 0);
    chk({tag, " addr_idle"}, 32'(tbl_addr), 0);
    chk({tag, " early_valid2"}, 32'(out_valid), 0);
    tick();
    out_ready = (hold == 0);
    @(negedge clk);
    chk({tag, " out_valid"}, 32'(out_valid), 1);
    chk({tag, " base"}, 32'(base), b);
    chk({tag, " next"}, 32'(next_data), n);
    chk({tag, " rem"}, 32'(remaining), r);
    for (int i = 1; i < hold; i++) begin
      tick();
      @(negedge clk);
      chk({tag, " hold_valid"}, 32'(out_valid), 1);
      chk({tag, " hold_base"}, 32'(base), b);
      chk({tag, " hold_next"}, 32'(next_data), n);
      chk({tag, " hold_rem"}, 32'(remaining), r);
      chk({tag, " hold_ready"}, 32'(in_ready), 0);
      chk({tag, " hold_rd"}, 32'(tbl_rd), 0);
    end
    if (hold > 0) begin
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, " release_valid"}, 32'(out_valid), 1);
      chk({tag, " release_base"}, 32'(base), b);
    end
    tick();
    @(negedge clk);
    chk({tag, " back_idle"}, 32'(fsm_state), 32'(IDLE));
    chk({tag, " back_ready"}, 32'(in_ready), 1);
    chk({tag, " back_valid"}, 32'(out_valid), 0);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    x = '0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst tbl_rd", 32'(tbl_rd), 0);
    chk("rst base", 32'(base), 0);
    chk("rst state", 32'(fsm_state), 32'(IDLE));
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst in_ready", 32'(in_ready), 1);

    // Main function and index boundaries
    run_fetch("x25", 8'h25, 10, 11, 30, 33, 5, 0);
    run_fetch("x7f", 8'h7F, 15, 15, 45, 45, 15, 0);
    run_fetch("x80", 8'h80, 0, 1, 0, 3, 0, 0);
    run_fetch("xf3", 8'hF3, 7, 8, 21, 24, 3, 0);

    // Backpressure in HOLD
    run_fetch("hold", 8'h25, 10, 11, 30, 33, 5, 5);

    // Reset during WAIT_BASE
    tick();
    in_valid = 1'b1;
    x = 8'h7F;
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst in_ready", 32'(in_ready), 0);
    chk("mid_rst tbl_rd", 32'(tbl_rd), 0);
    chk("mid_rst addr", 32'(tbl_addr), 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst state", 32'(fsm_state), 32'(IDLE));
    chk("mid_rst out_valid", 32'(out_valid), 0);
    chk("mid_rst base", 32'(base), 0);
    chk("mid_rst next", 32'(next_data), 0);
    chk("mid_rst rem", 32'(remaining), 0);
    chk("mid_rst rd", 32'(tbl_rd), 0);
    run_fetch("after_rst", 8'h25, 10, 11, 30, 33, 5, 0);

    // Same index as the previous sample
`ifdef ACT_TABLE_INDEX_CACHE_EN
    tick();
    in_valid = 1'b1;
    x = 8'h2A;
    @(negedge clk);
    chk("cache in_ready", 32'(in_ready), 1);
    chk("cache no_rd", 32'(tbl_rd), 0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("cache out_valid", 32'(out_valid), 1);
    chk("cache base", 32'(base), 30);
    chk("cache next", 32'(next_data), 33);
    chk("cache rem", 32'(remaining), 10);
    tick();
    @(negedge clk);
    chk("cache idle", 32'(fsm_state), 32'(IDLE));
`else
    run_fetch("x2a", 8'h2A, 10, 11, 30, 33, 10, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/activation_table_fetcher.md
ACTIVATION_TABLE_FETCHER -- requirements
Module: activation_table_fetcher

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 8, sample/table word width; FRAC_W, 4, fraction bits of input; ADDR_W, 4, table index width (2**ADDR_W entries).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 in_valid  in  1  input sample x valid.
REQ-005 in_ready  out  1  fetcher can accept x.
REQ-006 x  in  DATA_W signed  activation input, fixed point with FRAC_W fraction bits.
REQ-007 tbl_rd  out  1  table read strobe.
REQ-008 tbl_addr  out  ADDR_W  table read address.
REQ-009 tbl_data  in  DATA_W signed  table word, valid exactly 1 cycle after tbl_rd.
REQ-010 out_valid  out  1  interpolation operands valid.
REQ-011 out_ready  in  1  downstream interpolator accepts operands.
REQ-012 base, next_data, remaining  out  DATA_W signed each  operands for the downstream interpolator (result = base + ((next_data - base) * remaining) >> FRAC_W).

Function
REQ-013 Index SHALL be idx = x[DATA_W-1:FRAC_W] + 2**(ADDR_W-1), wrapping modulo 2**ADDR_W (signed integer part -8..7 maps to 0..15).
REQ-014 remaining SHALL be x[FRAC_W-1:0] zero-extended to DATA_W (range 0..15, never negative).
REQ-015 Next index SHALL be idx+1, clamped to 2**ADDR_W-1 when idx is the last entry (next_data == base there).
REQ-016 FSM states SHALL be IDLE, WAIT_BASE, WAIT_NEXT, HOLD.
REQ-017 IDLE: in_ready=1; on in_valid, latch idx and remaining, drive tbl_rd=1, tbl_addr=idx, go WAIT_BASE.
REQ-018 WAIT_BASE: capture tbl_data into base, drive tbl_rd=1, tbl_addr=next index, go WAIT_NEXT.
REQ-019 WAIT_NEXT: capture tbl_data into next_data, go HOLD.
REQ-020 HOLD: out_valid=1, base/next_data/remaining stable; on out_ready go IDLE.
REQ-021 Latency SHALL be 3 cycles from input handshake to out_valid; throughput one sample per 4 cycles minimum.
REQ-022 in_ready SHALL be 0 in every state except IDLE; tbl_rd SHALL be 0 outside the cycles named in REQ-017/018.
REQ-023 tbl_addr SHALL be 0 whenever tbl_rd is 0.
REQ-024 out_valid SHALL NOT drop without out_ready; operands SHALL NOT change while out_valid=1.

Reset
REQ-025 rst low at a clock edge SHALL force IDLE, out_valid=0, tbl_rd=0, tbl_addr=0, base=0, next_data=0, remaining=0, in_ready=0 during reset.
REQ-026 Reset mid-fetch SHALL abandon the fetch; a tbl_data returning after reset SHALL be ignored.

Configuration
REQ-027 Macro ACT_TABLE_INDEX_CACHE_EN SHALL enable an index cache: last fetched idx plus valid flag, invalidated by reset.
REQ-028 With the macro, an accepted x whose idx equals the cached idx SHALL skip table reads and reach HOLD next cycle (latency 1), updating only remaining.
REQ-029 Without the macro, every accepted x SHALL perform both table reads (REQ-017..019).

Structure
REQ-030 Package nn_interp_pkg SHALL hold DATA_W/FRAC_W/ADDR_W defaults and the FSM state enum type.
REQ-031 No sub-module SHALL be used; index split and clamp are inline logic.

Verification (bench ROM: tbl[k] = 3*k)
REQ-032 x=0x25 -> tbl_addr 10 then 11; 3 cycles later out_valid, base=30, next_data=33, remaining=5.
REQ-033 x=0x7F -> reads at 15 and 15; base=45, next_data=45, remaining=15.
REQ-034 x=0x80 -> idx 0; base=0, next_data=3, remaining=0.
REQ-035 out_ready held low 5 cycles in HOLD -> operands stable, in_ready=0, no tbl_rd; release -> IDLE next cycle.
REQ-036 rst low during WAIT_BASE -> next cycle all outputs zero, state IDLE; following x=0x25 produces REQ-032 result.
REQ-037 With ACT_TABLE_INDEX_CACHE_EN: x=0x25 then x=0x2A -> second has no tbl_rd, out_valid 1 cycle after accept, base=30, next_data=33, remaining=10.
